// File: rtl/fifo_rd_bridge_pkg.sv
//============================================================================
// fifo_rd_bridge_pkg : shared constants and types for fifo_rd_bridge (rev 1.0)
//============================================================================
`default_nettype none

package fifo_rd_bridge_pkg;
    localparam int c_occ_width     = 2;
    localparam int c_def_cnt_width = 16;

    typedef logic                   ptr_t;
    typedef logic [c_occ_width-1:0] occ_t;
endpackage

`default_nettype wire

// File: rtl/fifo_rd_bridge_buf2.sv
//============================================================================
// buf2 : 2-entry in-order buffer with occupancy output (rev 1.0)
//============================================================================
`default_nettype none

module buf2
    import fifo_rd_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    ptr_t                  r_wr_ptr;
    ptr_t                  r_rd_ptr;
    occ_t                  r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + occ_t'(push) - occ_t'(pop);
        end
    end

    assign dout = r_mem[r_rd_ptr];
    assign occ  = r_occ;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_bridge.sv
//============================================================================
// fifo_rd_bridge : sync-FIFO read port to valid/ready stream bridge (rev 1.0)
// Optional beat counter enabled by `define FIFO_RD_BRIDGE_BEAT_CNT_EN
//============================================================================
`default_nettype none

module fifo_rd_bridge
    import fifo_rd_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = c_def_cnt_width
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_BRIDGE_BEAT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

    logic                 r_infl;
    occ_t                 w_occ;
    logic                 w_pop;
    logic [c_occ_width:0] w_level;

    assign m_valid = (w_occ != '0);
    assign w_pop   = m_valid & m_ready;

    // Committed slots after this edge: buffered + in flight - leaving now.
    assign w_level    = {1'b0, w_occ}
                      + {{c_occ_width{1'b0}}, r_infl}
                      - {{c_occ_width{1'b0}}, w_pop};
    assign fifo_rd_en = rst_n & ~fifo_empty
                      & (w_level < (c_occ_width+1)'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_infl <= 1'b0;
        end else begin
            r_infl <= fifo_rd_en;
        end
    end

    buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf2 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_infl),
        .pop   (w_pop),
        .din   (fifo_data),
        .dout  (m_data),
        .occ   (w_occ)
    );

`ifdef FIFO_RD_BRIDGE_BEAT_CNT_EN
    logic [CNT_WIDTH-1:0] r_beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
        end
    end

    assign beat_cnt = r_beat_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_bridge.sv
//============================================================================
// tb_fifo_rd_bridge : bench with upstream FIFO model and output scoreboard (rev 1.0)
//============================================================================
`default_nettype none

module tb_fifo_rd_bridge;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data  = '0;
    logic          m_valid;
    logic          m_ready    = 1'b0;
    logic [DW-1:0] m_data;
`ifdef FIFO_RD_BRIDGE_BEAT_CNT_EN
    logic [CW-1:0] beat_cnt;
`endif

    always #5 clk = ~clk;

    fifo_rd_bridge #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_BRIDGE_BEAT_CNT_EN
        ,
        .beat_cnt   (beat_cnt)
`endif
    );

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            total = 0;
    int            bad   = 0;
    logic          s_rd, s_valid;
    logic [DW-1:0] s_data;
    int            beats;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_word = '0;
    logic [CW-1:0] cnt_exp = '0;

    typedef struct {
        logic          rdy;
        logic          rd;
        logic          vld;
        logic [DW-1:0] data;
    } vec_t;
    vec_t vec[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: sample mid-cycle, then advance the FIFO model after the edge.
    task automatic step();
        logic pop;
        @(negedge clk);
        s_rd    = fifo_rd_en;
        s_valid = m_valid;
        s_data  = m_data;
        pop     = m_valid & m_ready;
        check("rd_while_empty", 32'(fifo_rd_en & fifo_empty), 32'(0));
        @(posedge clk);
        #1;
        if (pop) begin
            beats++;
            cnt_exp = cnt_exp + CW'(1);
            if (exp_q.size() == 0) check("sb_underflow", 32'(1), 32'(0));
            else                   check("sb_data", 32'(s_data), 32'(exp_q.pop_front()));
        end
        if (s_rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        if (wr_en) begin
            fifo_q.push_back(wr_word);
            exp_q.push_back(wr_word);
        end
        fifo_empty = (fifo_q.size() == 0);
`ifdef FIFO_RD_BRIDGE_BEAT_CNT_EN
        check("beat_cnt", 32'(beat_cnt), 32'(cnt_exp));
`endif
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(m_valid), 32'(0));
        check("rst_data",  32'(m_data),  32'(0));
        check("rst_rd_en", 32'(fifo_rd_en), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_q   = fifo_q;
        cnt_exp = '0;
        beats   = 0;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        wr_en   = 1'b0;
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) step();
        repeat (3) step();
        check({name, "_left"}, 32'(exp_q.size()), 32'(0));
        check({name, "_idle"}, 32'(m_valid), 32'(0));
    endtask

    initial begin
        int reads, last_rd, last_vld;

        // back-to-back words after reset
        vec[0] = '{1'b1, 1'b1, 1'b0, 8'h00};
        vec[1] = '{1'b1, 1'b1, 1'b0, 8'h00};
        vec[2] = '{1'b1, 1'b1, 1'b1, 8'h24};
        vec[3] = '{1'b1, 1'b0, 1'b1, 8'h81};
        vec[4] = '{1'b1, 1'b0, 1'b1, 8'h09};
        vec[5] = '{1'b1, 1'b0, 1'b0, 8'h00};
        fifo_q.delete();
        fifo_q.push_back(8'h24);
        fifo_q.push_back(8'h81);
        fifo_q.push_back(8'h09);
        fifo_empty = 1'b0;
        m_ready    = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            m_ready = vec[i].rdy;
            step();
            check("vec_rd_en", 32'(s_rd),    32'(vec[i].rd));
            check("vec_valid", 32'(s_valid), 32'(vec[i].vld));
            if (vec[i].vld) check("vec_data", 32'(s_data), 32'(vec[i].data));
        end
        check("vec_beats", 32'(beats), 32'(3));

        // backpressure: only two reads, head word held stable
        m_ready = 1'b0;
        load(8, 8'h10);
        do_reset();
        reads = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (s_rd) reads++;
            if (c >= 2) begin
                check("bp_valid", 32'(s_valid), 32'(1));
                check("bp_hold",  32'(s_data),  32'(8'h10));
            end
        end
        check("bp_reads", 32'(reads), 32'(2));
        m_ready = 1'b1;
        step();
        check("bp_resume_rd", 32'(s_rd), 32'(1));
        drain("bp_drain");

        // FIFO runs dry after four words
        load(4, 8'hA0);
        m_ready = 1'b1;
        do_reset();
        last_rd  = -1;
        last_vld = -1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (s_rd)    last_rd  = c;
            if (s_valid) last_vld = c;
        end
        check("dry_beats",    32'(beats),    32'(4));
        check("dry_last_rd",  32'(last_rd),  32'(3));
        check("dry_latency",  32'(last_vld), 32'(last_rd + 2));

        // random ready with concurrent FIFO writes
        load(3, 8'h30);
        do_reset();
        for (int i = 0; i < 300; i++) begin
            wr_en   = 1'b1;
            wr_word = DW'(8'h33 + i);
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        wr_en = 1'b0;
        drain("rnd_drain");

        // reset mid-operation with one word buffered and one in flight
        load(6, 8'h50);
        m_ready = 1'b0;
        do_reset();
        step();
        step();
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 10 && !s_valid; k++) step();
        check("rst_mid_valid", 32'(s_valid), 32'(1));
        check("rst_mid_next",  32'(s_data),  32'(8'h52));
        drain("rst_mid_drain");

        // 17 beats: counter wraps at CW bits
        load(17, 8'hC0);
        m_ready = 1'b1;
        do_reset();
        drain("wrap_drain");
        check("wrap_beats", 32'(beats), 32'(17));
`ifdef FIFO_RD_BRIDGE_BEAT_CNT_EN
        check("wrap_cnt", 32'(beat_cnt), 32'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
